// File: rtl/ps2_letter_transmitter.sv
// Turns a letter index (0=A..25=Z) into a PS/2 Set-2 make/break keystroke (code, F0, code) sent as device-to-host frames.
// A new letter is accepted only while ready is high, and ready stays low until all three frames and their gaps are done.
module ps2_letter_transmitter #(
  parameter int CLK_DIV    = 2000,
  parameter int GAP_CYCLES = 4000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] letter,
  input  logic       valid,
  output logic       ready,
  output logic       err,
  input  logic       ps2_clk_in,
  output logic       ps2_clk_out,
  output logic       ps2_data_out
);

  localparam int CELL = 2 * CLK_DIV;
  localparam int MAXC = (CELL > GAP_CYCLES) ? CELL : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HALF_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CELL_END = CW'(CELL - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, INHIBIT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    bit_idx, bit_n;
  logic [1:0]    byte_idx, byte_n;
  logic [7:0]    code, code_n;
  logic          retry, retry_n;
  logic          err_n, clk_n, dat_n;
  logic          sync1, sync2;
  logic [7:0]    cur_byte;
  logic [10:0]   frame;
  logic [3:0]    next_bit;

  function automatic logic [7:0] scan_code(input logic [4:0] idx);
    case (idx)
      5'd0:  scan_code = 8'h1C;
      5'd1:  scan_code = 8'h32;
      5'd2:  scan_code = 8'h21;
      5'd3:  scan_code = 8'h23;
      5'd4:  scan_code = 8'h24;
      5'd5:  scan_code = 8'h2B;
      5'd6:  scan_code = 8'h34;
      5'd7:  scan_code = 8'h33;
      5'd8:  scan_code = 8'h43;
      5'd9:  scan_code = 8'h3B;
      5'd10: scan_code = 8'h42;
      5'd11: scan_code = 8'h4B;
      5'd12: scan_code = 8'h3A;
      5'd13: scan_code = 8'h31;
      5'd14: scan_code = 8'h44;
      5'd15: scan_code = 8'h4D;
      5'd16: scan_code = 8'h15;
      5'd17: scan_code = 8'h2D;
      5'd18: scan_code = 8'h1B;
      5'd19: scan_code = 8'h2C;
      5'd20: scan_code = 8'h3C;
      5'd21: scan_code = 8'h2A;
      5'd22: scan_code = 8'h1D;
      5'd23: scan_code = 8'h22;
      5'd24: scan_code = 8'h35;
      5'd25: scan_code = 8'h1A;
      default: scan_code = 8'h00;
    endcase
  endfunction

  // Idle-high reset keeps a freshly started frame from seeing a phantom inhibit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= ps2_clk_in;
      sync2 <= sync1;
    end
  end

  assign cur_byte = (byte_idx == 2'd1) ? 8'hF0 : code;
  assign frame    = {1'b1, ~^cur_byte, cur_byte, 1'b0};
  assign next_bit = bit_idx + 4'd1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      byte_idx     <= '0;
      code         <= '0;
      retry        <= 1'b0;
      ready        <= 1'b1;
      err          <= 1'b0;
      ps2_clk_out  <= 1'b1;
      ps2_data_out <= 1'b1;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bit_idx      <= bit_n;
      byte_idx     <= byte_n;
      code         <= code_n;
      retry        <= retry_n;
      ready        <= (state_n == IDLE);
      err          <= err_n;
      ps2_clk_out  <= clk_n;
      ps2_data_out <= dat_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    code_n  = code;
    retry_n = retry;
    err_n   = 1'b0;
    clk_n   = ps2_clk_out;
    dat_n   = ps2_data_out;
    case (state)
      IDLE: begin
        clk_n = 1'b1;
        dat_n = 1'b1;
        if (valid) begin
          if (letter > 5'd25) begin
            err_n = 1'b1;
          end else begin
            code_n  = scan_code(letter);
            state_n = SEND;
            cnt_n   = '0;
            bit_n   = '0;
            byte_n  = '0;
            retry_n = 1'b0;
            dat_n   = 1'b0;
          end
        end
      end
      SEND: begin
        // Host inhibit is only honoured while our clock is released, and never in the stop cell.
        if (ps2_clk_out && (bit_idx != 4'd10) && !sync2) begin
          state_n = INHIBIT;
          cnt_n   = '0;
          retry_n = 1'b1;
          clk_n   = 1'b1;
          dat_n   = 1'b1;
        end else if (cnt == CELL_END) begin
          cnt_n = '0;
          clk_n = 1'b1;
          if (bit_idx == 4'd10) begin
            state_n = GAP;
            retry_n = 1'b0;
            dat_n   = 1'b1;
          end else begin
            bit_n = next_bit;
            dat_n = frame[next_bit];
          end
        end else begin
          cnt_n = cnt + 1'b1;
          if (cnt == HALF_END) clk_n = 1'b0;
        end
      end
      GAP: begin
        clk_n = 1'b1;
        dat_n = 1'b1;
        if (!sync2) begin
          cnt_n = '0;
        end else if (cnt == GAP_END) begin
          cnt_n = '0;
          if (!retry && (byte_idx == 2'd2)) begin
            state_n = IDLE;
            byte_n  = '0;
          end else begin
            state_n = SEND;
            if (!retry) byte_n = byte_idx + 2'd1;
            retry_n = 1'b0;
            bit_n   = '0;
            dat_n   = 1'b0;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      INHIBIT: begin
        clk_n = 1'b1;
        dat_n = 1'b1;
        if (sync2) begin
          state_n = GAP;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ps2_letter_transmitter.sv
// Directed bench: frames are captured off the PS/2 lines on each clock fall and compared with hand-built scan-code frames.
module tb_ps2_letter_transmitter;
  localparam int CD = 4;
  localparam int GP = 8;

  // Frames as {stop, parity, D7..D0, start}
  localparam logic [10:0] F_1C = 11'b10000111000;
  localparam logic [10:0] F_F0 = 11'b11111100000;
  localparam logic [10:0] F_1A = 11'b10000110100;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] letter = '0;
  logic       valid = 1'b0;
  logic       ps2_clk_in = 1'b1;
  logic       ready, err, ps2_clk_out, ps2_data_out;

  int checks = 0;
  int errors = 0;

  logic [7:0] scan_tab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  ps2_letter_transmitter #(.CLK_DIV(CD), .GAP_CYCLES(GP)) dut (
    .clock(clock), .reset_n(reset_n), .letter(letter), .valid(valid), .ready(ready), .err(err),
    .ps2_clk_in(ps2_clk_in), .ps2_clk_out(ps2_clk_out), .ps2_data_out(ps2_data_out)
  );

  always #5 clock = ~clock;

  // Receiver: shift data on each falling ps2 clock; a long both-high stretch abandons a partial frame.
  logic [10:0] frames[$];
  int          partials = 0;
  int          falls = 0;
  logic        prev_clk = 1'b1;
  logic [10:0] sh = '0;
  logic [3:0]  nb = '0;
  int          idle_run = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      nb = '0;
      idle_run = 0;
    end else begin
      if (prev_clk && !ps2_clk_out) begin
        sh[nb] = ps2_data_out;
        nb = nb + 4'd1;
        falls++;
        if (nb == 4'd11) begin
          frames.push_back(sh);
          nb = '0;
        end
      end
      if (ps2_clk_out && ps2_data_out) begin
        idle_run++;
        if (idle_run >= 2 * CD && nb != 4'd0) begin
          partials++;
          nb = '0;
        end
      end else begin
        idle_run = 0;
      end
    end
    prev_clk = ps2_clk_out;
  end

  task automatic send(input logic [4:0] l);
    @(negedge clock);
    letter = l;
    valid = 1'b1;
    @(negedge clock);
    valid = 1'b0;
  endtask

  task automatic wait_ready(input int budget, input string name);
    int n = 0;
    while (!ready && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!ready) begin
      errors++;
      $display("FAIL %s: ready still %b after %0d cycles, required 1", name, ready, budget);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({ready, err, ps2_clk_out, ps2_data_out} !== 4'b1011) begin
      errors++;
      $display("FAIL reset_state: {ready,err,clk,data}=%b required 1011", {ready, err, ps2_clk_out, ps2_data_out});
    end
  endtask

  task automatic test_basic();
    logic [10:0] exp3 [3];
    logic [10:0] fr;
    int bad = 0;
    int low = 0;
    int f, r;
    logic ec, ed;
    exp3 = '{F_1C, F_F0, F_1C};
    frames.delete();
    falls = 0;
    send(5'd0);
    for (int i = 0; i < 288; i++) begin
      f = i / 96;
      r = i % 96;
      fr = exp3[f];
      if (r < 88) begin
        ec = ((r % 8) < 4);
        ed = fr[r / 8];
      end else begin
        ec = 1'b1;
        ed = 1'b1;
      end
      if (!ready) low++;
      if (ps2_clk_out !== ec || ps2_data_out !== ed || ready !== 1'b0) begin
        if (bad == 0)
          $display("note first waveform difference at cycle %0d: clk=%b data=%b ready=%b expected %b %b 0",
                   i, ps2_clk_out, ps2_data_out, ready, ec, ed);
        bad++;
      end
      @(negedge clock);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_waveform: %0d cycles differ, required 0", bad);
    end
    checks++;
    if (low != 288 || ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_ready_low: low %0d cycles then ready=%b, required 288 then 1", low, ready);
    end
    checks++;
    if (frames.size() != 3 || frames[0] !== F_1C || frames[1] !== F_F0 || frames[2] !== F_1C) begin
      errors++;
      $display("FAIL basic_frames: got %0d frames first %h, required 1C,F0,1C frames", frames.size(),
               frames.size() > 0 ? frames[0] : 11'h0);
    end
    checks++;
    if (falls != 33) begin
      errors++;
      $display("FAIL basic_clock_pulses: %0d falls, required 33", falls);
    end
  endtask

  task automatic test_err();
    logic [4:0] bad_letters [2];
    bad_letters = '{5'd26, 5'd31};
    frames.delete();
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      letter = bad_letters[k];
      valid = 1'b1;
      @(negedge clock);
      valid = 1'b0;
      checks++;
      if ({err, ready, ps2_clk_out, ps2_data_out} !== 4'b1111) begin
        errors++;
        $display("FAIL err_pulse_%0d: {err,ready,clk,data}=%b required 1111", bad_letters[k],
                 {err, ready, ps2_clk_out, ps2_data_out});
      end
      @(negedge clock);
      checks++;
      if (err !== 1'b0 || ready !== 1'b1) begin
        errors++;
        $display("FAIL err_one_cycle_%0d: err=%b ready=%b required 0 1", bad_letters[k], err, ready);
      end
    end
    repeat (20) @(negedge clock);
    checks++;
    if (frames.size() != 0 || ps2_clk_out !== 1'b1 || ps2_data_out !== 1'b1) begin
      errors++;
      $display("FAIL err_no_frames: %0d frames, lines %b%b, required 0 frames, lines 11", frames.size(),
               ps2_clk_out, ps2_data_out);
    end
  endtask

  task automatic test_ignore();
    int low = 0;
    frames.delete();
    send(5'd2);
    for (int i = 0; i < 288; i++) begin
      if (i == 40) begin
        letter = 5'd1;
        valid = 1'b1;
      end
      if (i == 41) valid = 1'b0;
      if (!ready) low++;
      @(negedge clock);
    end
    checks++;
    if (low != 288 || ready !== 1'b1) begin
      errors++;
      $display("FAIL ignore_ready: low %0d then ready=%b, required 288 then 1", low, ready);
    end
    repeat (300) @(negedge clock);
    checks++;
    if (frames.size() != 3 || frames[0][8:1] !== 8'h21 || frames[1][8:1] !== 8'hF0 ||
        frames[2][8:1] !== 8'h21 || ready !== 1'b1) begin
      errors++;
      $display("FAIL ignore_frames: %0d frames ready=%b, required 3 frames 21,F0,21 and ready 1",
               frames.size(), ready);
    end
  endtask

  task automatic test_all_letters();
    logic [10:0] a, b, c;
    frames.delete();
    for (int l = 0; l < 26; l++) begin
      wait_ready(400, "all_wait");
      send(5'(l));
    end
    wait_ready(400, "all_final");
    checks++;
    if (frames.size() != 78) begin
      errors++;
      $display("FAIL all_count: %0d frames, required 78", frames.size());
    end else begin
      for (int l = 0; l < 26; l++) begin
        a = frames[3 * l];
        b = frames[3 * l + 1];
        c = frames[3 * l + 2];
        checks++;
        if (a[8:1] !== scan_tab[l] || b[8:1] !== 8'hF0 || c[8:1] !== scan_tab[l]) begin
          errors++;
          $display("FAIL all_codes_%0d: got %h %h %h required %h F0 %h", l, a[8:1], b[8:1], c[8:1],
                   scan_tab[l], scan_tab[l]);
        end
        checks++;
        if (^a[9:1] !== 1'b1 || ^b[9:1] !== 1'b1 || ^c[9:1] !== 1'b1 ||
            a[0] !== 1'b0 || a[10] !== 1'b1 || c[0] !== 1'b0 || c[10] !== 1'b1) begin
          errors++;
          $display("FAIL all_framing_%0d: frames %b %b %b need odd parity, start 0, stop 1", l, a, b, c);
        end
      end
    end
  endtask

  task automatic test_inhibit();
    int low = 0;
    frames.delete();
    partials = 0;
    send(5'd0);
    for (int i = 0; i < 600 && (i == 0 || !ready); i++) begin
      if (i == 128) ps2_clk_in = 1'b0;
      if (i == 148) ps2_clk_in = 1'b1;
      if (i == 138) begin
        checks++;
        if (ps2_clk_out !== 1'b1 || ps2_data_out !== 1'b1) begin
          errors++;
          $display("FAIL inhibit_release: lines %b%b during inhibit, required 11", ps2_clk_out, ps2_data_out);
        end
      end
      if (!ready) low++;
      @(negedge clock);
    end
    checks++;
    if (low != 351 || ready !== 1'b1) begin
      errors++;
      $display("FAIL inhibit_duration: ready low %0d cycles, ready=%b, required 351 then 1", low, ready);
    end
    checks++;
    if (frames.size() != 3 || frames[0] !== F_1C || frames[1] !== F_F0 || frames[2] !== F_1C) begin
      errors++;
      $display("FAIL inhibit_frames: %0d frames, required 1C,F0,1C", frames.size());
    end
    checks++;
    if (partials != 1) begin
      errors++;
      $display("FAIL inhibit_partial: %0d abandoned frames, required 1", partials);
    end
  endtask

  task automatic test_reset_midframe();
    frames.delete();
    send(5'd0);
    for (int i = 0; i < 53; i++) @(negedge clock);
    checks++;
    if (ps2_clk_out !== 1'b0 || ps2_data_out !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL midframe_state: clk=%b data=%b ready=%b at bit 6, required 0 0 0", ps2_clk_out,
               ps2_data_out, ready);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ps2_clk_out !== 1'b1 || ps2_data_out !== 1'b1 || ready !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: clk=%b data=%b ready=%b err=%b, required 1 1 1 0", ps2_clk_out,
               ps2_data_out, ready, err);
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    frames.delete();
    send(5'd25);
    wait_ready(400, "z_done");
    checks++;
    if (frames.size() != 3 || frames[0] !== F_1A || frames[1] !== F_F0 || frames[2] !== F_1A) begin
      errors++;
      $display("FAIL after_reset_frames: %0d frames, required 1A,F0,1A", frames.size());
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    test_reset();
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    test_reset();
    test_basic();
    test_err();
    test_ignore();
    test_all_letters();
    test_inhibit();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
